seven_seg_rx: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 28 ++
 rtl/seven_seg_dec.sv | 29 ++
 rtl/seven_seg_rx.sv | 134 +++++++++++++
 tb/tb_seven_seg_rx.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the 7-segment display bus receiver and its decoder.
package seven_seg_pkg;

    // Segment patterns, {a,b,c,d,e,f,g}, active-high
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    localparam int DIG_ONES = 0;
    localparam int DIG_TENS = 1;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_HAVE_ONES,
        ST_HAVE_TENS
    } frame_state_e;

endpackage

// File: rtl/seven_seg_dec.sv
// Combinational segment-pattern to BCD decoder; blank decodes to BCD_BLANK, anything else is illegal.
module seven_seg_dec
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       legal_o,
    output logic [3:0] bcd_o
);

    always_comb begin
        legal_o = 1'b1;
        bcd_o   = BCD_BLANK;
        case (seg_i)
            SEG_0:     bcd_o = 4'd0;
            SEG_1:     bcd_o = 4'd1;
            SEG_2:     bcd_o = 4'd2;
            SEG_3:     bcd_o = 4'd3;
            SEG_4:     bcd_o = 4'd4;
            SEG_5:     bcd_o = 4'd5;
            SEG_6:     bcd_o = 4'd6;
            SEG_7:     bcd_o = 4'd7;
            SEG_8:     bcd_o = 4'd8;
            SEG_9:     bcd_o = 4'd9;
            SEG_BLANK: bcd_o = BCD_BLANK;
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_rx.sv
// Two-digit multiplexed 7-segment bus receiver: samples, waits for a stable pattern,
// decodes each digit and publishes a {tens, ones} BCD frame once both digits are seen.
module seven_seg_rx
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           seg_data,
    input  logic [1:0]           dig_en,
    output logic [7:0]           bcd_out,
    output logic                 frame_valid,
    output logic [1:0]           digit_valid,
    output logic                 seg_err,
    output logic                 err_digit,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int             CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [8:0]           sample_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 same, cap, cap_ones, cap_tens;
    logic                 dec_legal;
    logic [3:0]           dec_bcd;

    frame_state_e         state_q, state_d;
    logic [3:0]           ones_q, ones_d, tens_q, tens_d;
    logic [7:0]           bcd_q, bcd_d;
    logic                 fv_q, fv_d, err_q, err_d, errdig_q, errdig_d;
    logic [1:0]           dv_q, dv_d;
    logic [ERR_CNT_W-1:0] errcnt_q, errcnt_d;

    seven_seg_dec u_dec (
        .seg_i   (sample_q[6:0]),
        .legal_o (dec_legal),
        .bcd_o   (dec_bcd)
    );

    // The incoming sample is compared against the registered one; done_q keeps a
    // window that stays stable past saturation from capturing a second time.
    always_comb begin
        same   = ({dig_en, seg_data} == sample_q);
        cnt_d  = '0;
        done_d = 1'b0;
        cap    = 1'b0;
        if (same) begin
            cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            cap    = (cnt_q == CNT_MAX) && !done_q;
            done_d = done_q | cap;
        end
        cap_ones = cap && (sample_q[8:7] == 2'b01);
        cap_tens = cap && (sample_q[8:7] == 2'b10);
    end

    always_comb begin
        state_d  = state_q;
        ones_d   = ones_q;
        tens_d   = tens_q;
        bcd_d    = bcd_q;
        fv_d     = 1'b0;
        dv_d     = 2'b00;
        err_d    = 1'b0;
        errdig_d = errdig_q;
        errcnt_d = errcnt_q;
        if ((cap_ones || cap_tens) && !dec_legal) begin
            err_d    = 1'b1;
            errdig_d = cap_tens;
            if (errcnt_q != '1) errcnt_d = errcnt_q + 1'b1;
        end else if (cap_ones) begin
            dv_d[DIG_ONES] = 1'b1;
            ones_d         = dec_bcd;
            if (state_q == ST_HAVE_TENS) begin
                bcd_d   = {tens_q, dec_bcd};
                fv_d    = 1'b1;
                state_d = ST_EMPTY;
            end else begin
                state_d = ST_HAVE_ONES;
            end
        end else if (cap_tens) begin
            dv_d[DIG_TENS] = 1'b1;
            tens_d         = dec_bcd;
            if (state_q == ST_HAVE_ONES) begin
                bcd_d   = {dec_bcd, ones_q};
                fv_d    = 1'b1;
                state_d = ST_EMPTY;
            end else begin
                state_d = ST_HAVE_TENS;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            state_q  <= ST_EMPTY;
            ones_q   <= BCD_BLANK;
            tens_q   <= BCD_BLANK;
            bcd_q    <= 8'hFF;
            fv_q     <= 1'b0;
            dv_q     <= 2'b00;
            err_q    <= 1'b0;
            errdig_q <= 1'b0;
            errcnt_q <= '0;
        end else begin
            sample_q <= {dig_en, seg_data};
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            state_q  <= state_d;
            ones_q   <= ones_d;
            tens_q   <= tens_d;
            bcd_q    <= bcd_d;
            fv_q     <= fv_d;
            dv_q     <= dv_d;
            err_q    <= err_d;
            errdig_q <= errdig_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign frame_valid = fv_q;
    assign digit_valid = dv_q;
    assign seg_err     = err_q;
    assign err_digit   = errdig_q;
    assign err_cnt     = errcnt_q;

endmodule

// File: tb/tb_seven_seg_rx.sv
// Directed bench for seven_seg_rx: timing of capture, frame assembly, glitch rejection,
// illegal patterns, blank/overwrite, disabled enables, counter saturation and async reset.
module tb_seven_seg_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_data;
    logic [1:0] dig_en;
    logic [7:0] bcd_out;
    logic       frame_valid;
    logic [1:0] digit_valid;
    logic       seg_err;
    logic       err_digit;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int dv0_n, dv1_n, fv_n, err_n, cap_edge;

    seven_seg_rx #(.STABLE_CYCLES(4), .ERR_CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_data    (seg_data),
        .dig_en      (dig_en),
        .bcd_out     (bcd_out),
        .frame_valid (frame_valid),
        .digit_valid (digit_valid),
        .seg_err     (seg_err),
        .err_digit   (err_digit),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        dv0_n = 0; dv1_n = 0; fv_n = 0; err_n = 0;
    endtask

    // Holds a pattern for n edges, sampling outputs 1ns after each edge.
    // cap_edge records the first edge (1 = sampling edge) showing a capture pulse.
    task automatic drive(input logic [1:0] d, input logic [6:0] s, input int n);
        dig_en   = d;
        seg_data = s;
        cap_edge = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            dv0_n += int'(digit_valid[0]);
            dv1_n += int'(digit_valid[1]);
            fv_n  += int'(frame_valid);
            err_n += int'(seg_err);
            if ((digit_valid != 2'b00 || seg_err) && cap_edge == 0) cap_edge = k;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        seg_data = 7'b0;
        dig_en   = 2'b00;
        #12;
        chk("rst_bcd",    bcd_out, 8'hFF);
        chk("rst_errcnt", err_cnt, 8'h00);
        chk("rst_pulses", {frame_valid, digit_valid, seg_err, err_digit}, 5'b0);
        rst_n = 1'b1;

        // Basic frame: ones=5 then tens=1
        clr();
        drive(2'b01, 7'b1011011, 6);
        chk("f1_ones_dv",   dv0_n, 1);
        chk("f1_ones_edge", cap_edge, 5);
        chk("f1_no_frame",  fv_n, 0);
        drive(2'b10, 7'b0110000, 6);
        chk("f1_tens_dv",   dv1_n, 1);
        chk("f1_tens_edge", cap_edge, 5);
        chk("f1_frame",     fv_n, 1);
        chk("f1_bcd",       bcd_out, 8'h15);

        // Glitch rejection: every pattern held only 3 edges
        clr();
        drive(2'b01, 7'b1111001, 3);
        drive(2'b01, 7'b1111111, 3);
        drive(2'b10, 7'b1101101, 3);
        drive(2'b01, 7'b0000001, 3);
        drive(2'b10, 7'b0110011, 3);
        chk("gl_dv",  dv0_n + dv1_n, 0);
        chk("gl_err", err_n, 0);
        chk("gl_bcd", bcd_out, 8'h15);

        // Illegal pattern on tens
        clr();
        drive(2'b10, 7'b0000001, 5);
        chk("il_err",    err_n, 1);
        chk("il_edge",   cap_edge, 5);
        chk("il_digit",  err_digit, 1'b1);
        chk("il_cnt",    err_cnt, 8'd1);
        chk("il_dv",     dv0_n + dv1_n, 0);
        drive(2'b01, 7'b0110011, 6);
        drive(2'b10, 7'b1101101, 6);
        chk("il_frame",  fv_n, 1);
        chk("il_bcd",    bcd_out, 8'h24);

        // Overwrite ones with blank, then tens=9
        clr();
        drive(2'b01, 7'b1110000, 6);
        drive(2'b01, 7'b0000000, 6);
        chk("ow_dv0",    dv0_n, 2);
        chk("ow_nofr",   fv_n, 0);
        chk("ow_hold",   bcd_out, 8'h24);
        drive(2'b10, 7'b1111011, 6);
        chk("ow_frame",  fv_n, 1);
        chk("ow_bcd",    bcd_out, 8'h9F);

        // Both enables and no enable: nothing captured
        clr();
        drive(2'b11, 7'b1011011, 10);
        drive(2'b00, 7'b1011011, 10);
        drive(2'b11, 7'b0000001, 10);
        chk("en_dv",     dv0_n + dv1_n, 0);
        chk("en_err",    err_n, 0);
        chk("en_fr",     fv_n, 0);
        chk("en_cnt",    err_cnt, 8'd1);

        // Saturation: 260 illegal captures on ones
        clr();
        for (int i = 0; i < 130; i++) begin
            drive(2'b01, 7'b0000001, 5);
            drive(2'b01, 7'b0000010, 5);
        end
        chk("sat_err_n", err_n, 260);
        chk("sat_cnt",   err_cnt, 8'hFF);
        chk("sat_digit", err_digit, 1'b0);
        chk("sat_bcd",   bcd_out, 8'h9F);

        // Async reset mid-frame, right after a ones capture pulse
        clr();
        drive(2'b01, 7'b1111001, 5);
        chk("mr_pre_dv", digit_valid, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("mr_bcd",    bcd_out, 8'hFF);
        chk("mr_cnt",    err_cnt, 8'h00);
        chk("mr_pulses", {frame_valid, digit_valid, seg_err, err_digit}, 5'b0);
        #3;
        rst_n = 1'b1;
        clr();
        drive(2'b10, 7'b1011111, 6);
        chk("mr_tens_dv", dv1_n, 1);
        chk("mr_nofr",    fv_n, 0);
        drive(2'b01, 7'b1111001, 6);
        chk("mr_frame",   fv_n, 1);
        chk("mr_bcd2",    bcd_out, 8'h63);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
